// File: rtl/bcd2gray_rr_arbiter.sv
// Round-robin arbiter that shares one BCD-to-Gray converter among N_REQ requesters.
// Optional saturating error counter enabled by defining BCD2GRAY_ARB_ERRCNT_EN.
module bcd2gray_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [4*N_REQ-1:0]   req_bcd,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_gray,
  output logic [ID_W-1:0]      out_id,
  output logic                 out_err
`ifdef BCD2GRAY_ARB_ERRCNT_EN
  ,
  input  logic                 err_clr,
  output logic [7:0]           err_cnt
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic            load;
  logic            hi_any, lo_any, gnt_any;
  logic [ID_W-1:0] hi_id, lo_id, gnt_id;
  logic [3:0]      gnt_bcd;
  logic            gnt_bad;

  function automatic logic [3:0] conv(input logic [3:0] d);
    case (d)
      4'd0: conv = 4'b0000;
      4'd1: conv = 4'b0001;
      4'd2: conv = 4'b0011;
      4'd3: conv = 4'b0010;
      4'd4: conv = 4'b0110;
      4'd5: conv = 4'b0111;
      4'd6: conv = 4'b0101;
      4'd7: conv = 4'b0100;
      4'd8: conv = 4'b1100;
      4'd9: conv = 4'b1101;
      default: conv = 4'b1111;
    endcase
  endfunction

  assign load = (state == EMPTY) || out_ready;

  // Wrap-around search: first valid index above rr_ptr, else lowest valid index.
  always_comb begin
    hi_any = 1'b0;
    hi_id  = '0;
    lo_any = 1'b0;
    lo_id  = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!hi_any && req_valid[j] && (j > int'(rr_ptr))) begin
        hi_any = 1'b1;
        hi_id  = ID_W'(j);
      end
      if (!lo_any && req_valid[j]) begin
        lo_any = 1'b1;
        lo_id  = ID_W'(j);
      end
    end
    gnt_any = load && lo_any;
    gnt_id  = hi_any ? hi_id : lo_id;
  end

  always_comb begin
    req_ready = '0;
    gnt_bcd   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (gnt_id == ID_W'(j)) begin
        req_ready[j] = gnt_any;
        gnt_bcd      = req_bcd[4*j +: 4];
      end
    end
  end

  assign gnt_bad = (gnt_bcd > 4'd9);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_gray  <= '0;
      out_id    <= '0;
      out_err   <= 1'b0;
      rr_ptr    <= ID_W'(N_REQ-1);
    end else if (load) begin
      if (gnt_any) begin
        state     <= FULL;
        out_valid <= 1'b1;
        out_gray  <= conv(gnt_bcd);
        out_id    <= gnt_id;
        out_err   <= gnt_bad;
        rr_ptr    <= gnt_id;
      end else begin
        state     <= EMPTY;
        out_valid <= 1'b0;
      end
    end
  end

`ifdef BCD2GRAY_ARB_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_cnt <= '0;
    else if (err_clr)
      err_cnt <= '0;
    else if (gnt_any && gnt_bad && (err_cnt != 8'hFF))
      err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_bcd2gray_rr_arbiter.sv
// Directed bench for bcd2gray_rr_arbiter: inputs driven and outputs sampled on the falling edge.
// Counter scenario is included when BCD2GRAY_ARB_ERRCNT_EN is defined.
module tb_bcd2gray_rr_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_bcd;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_gray;
  logic [1:0]  out_id;
  logic        out_err;
`ifdef BCD2GRAY_ARB_ERRCNT_EN
  logic        err_clr;
  logic [7:0]  err_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bcd2gray_rr_arbiter #(.N_REQ(4), .ID_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_bcd(req_bcd), .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_gray(out_gray), .out_id(out_id), .out_err(out_err)
`ifdef BCD2GRAY_ARB_ERRCNT_EN
    , .err_clr(err_clr), .err_cnt(err_cnt)
`endif
  );

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_gray !== 4'b0000 || out_id !== 2'd0 || out_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%b gray=%b id=%0d err=%b, want 0 0000 0 0",
               out_valid, out_gray, out_id, out_err);
    end
    tests++;
    if (req_ready !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    req_valid = 4'b0001;
    req_bcd   = 16'h0005;
    out_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL single_grant: got %b want 0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    tests++;
    if (out_valid !== 1'b1 || out_gray !== 4'b0111 || out_id !== 2'd0 || out_err !== 1'b0) begin
      fails++;
      $display("FAIL single_out: valid=%b gray=%b id=%0d err=%b, want 1 0111 0 0",
               out_valid, out_gray, out_id, out_err);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [5]    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] exp_gray [5] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0001};
    pulse_reset();
    req_valid = 4'b1111;
    req_bcd   = 16'h4321;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++;
      if (req_ready !== (4'b0001 << exp_g[i])) begin
        fails++;
        $display("FAIL rr_grant[%0d]: got %b want %b", i, req_ready, 4'b0001 << exp_g[i]);
      end
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || out_gray !== exp_gray[i] || out_id !== exp_g[i]) begin
        fails++;
        $display("FAIL rr_out[%0d]: valid=%b gray=%b id=%0d, want 1 %b %0d",
                 i, out_valid, out_gray, out_id, exp_gray[i], exp_g[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    // Holding result: digit 1 from requester 0.
    req_valid = 4'b0010;
    req_bcd   = 16'h0090;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (req_ready !== 4'b0000) begin
        fails++;
        $display("FAIL hold_ready[%0d]: got %b want 0000", i, req_ready);
      end
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || out_gray !== 4'b0001 || out_id !== 2'd0) begin
        fails++;
        $display("FAIL hold_out[%0d]: valid=%b gray=%b id=%0d, want 1 0001 0",
                 i, out_valid, out_gray, out_id);
      end
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0010) begin
      fails++;
      $display("FAIL release_grant: got %b want 0010", req_ready);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || out_gray !== 4'b1101 || out_id !== 2'd1 || out_err !== 1'b0) begin
      fails++;
      $display("FAIL release_out: valid=%b gray=%b id=%0d err=%b, want 1 1101 1 0",
               out_valid, out_gray, out_id, out_err);
    end
  endtask

  task automatic test_invalid_bcd();
    logic [3:0]  vld  [3] = '{4'b0100, 4'b1000, 4'b0001};
    logic [15:0] bcd  [3] = '{16'h0C00, 16'h9000, 16'h000A};
    logic [3:0]  gray [3] = '{4'b1111, 4'b1101, 4'b1111};
    logic [1:0]  id   [3] = '{2'd2, 2'd3, 2'd0};
    logic        err  [3] = '{1'b1, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid = vld[i];
      req_bcd   = bcd[i];
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || out_gray !== gray[i] || out_id !== id[i] || out_err !== err[i]) begin
        fails++;
        $display("FAIL bcd_err[%0d]: valid=%b gray=%b id=%0d err=%b, want 1 %b %0d %b",
                 i, out_valid, out_gray, out_id, out_err, gray[i], id[i], err[i]);
      end
    end
    req_valid = 4'b0000;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL idle_empty: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    req_valid = 4'b0010;
    req_bcd   = 16'h0070;
    out_ready = 1'b0;
    @(negedge clk);
    req_valid = 4'b0000;
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_id !== 2'd0 || out_gray !== 4'b0000) begin
      fails++;
      $display("FAIL async_reset: valid=%b gray=%b id=%0d, want 0 0000 0", out_valid, out_gray, out_id);
    end
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 4'b1111;
    req_bcd   = 16'h8888;
    out_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL post_reset_grant: got %b want 0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    tests++;
    if (out_valid !== 1'b1 || out_id !== 2'd0 || out_gray !== 4'b1100) begin
      fails++;
      $display("FAIL post_reset_out: valid=%b gray=%b id=%0d, want 1 1100 0", out_valid, out_gray, out_id);
    end
    @(negedge clk);
  endtask

`ifdef BCD2GRAY_ARB_ERRCNT_EN
  task automatic test_err_cnt();
    pulse_reset();
    tests++;
    if (err_cnt !== 8'd0) begin
      fails++;
      $display("FAIL errcnt_reset: got %0d want 0", err_cnt);
    end
    req_valid = 4'b0001;
    req_bcd   = 16'h000F;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (err_cnt !== 8'd3) begin
      fails++;
      $display("FAIL errcnt_count: got %0d want 3", err_cnt);
    end
    repeat (297) @(negedge clk);
    tests++;
    if (err_cnt !== 8'd255) begin
      fails++;
      $display("FAIL errcnt_sat: got %0d want 255", err_cnt);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr   = 1'b0;
    req_valid = 4'b0000;
    tests++;
    if (err_cnt !== 8'd0) begin
      fails++;
      $display("FAIL errcnt_clr: got %0d want 0", err_cnt);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_bcd   = '0;
    out_ready = 1'b0;
`ifdef BCD2GRAY_ARB_ERRCNT_EN
    err_clr   = 1'b0;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_invalid_bcd();
    test_async_reset();
`ifdef BCD2GRAY_ARB_ERRCNT_EN
    test_err_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
